// File: rtl/exp_align_sched_16in.sv
// Finds max exponent and per-element right shifts of a 16-exponent vector via one shared 4-input compare unit.
// Result 6 cycles after accept (4 group passes + 1 final pass); holds result in DONE until out_ready, no accept meanwhile.
module exp_align_sched_16in #(
  parameter int WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WIDTH-1:0]   in_exp,
  output logic [WIDTH-1:0]      cmp_exp_0,
  output logic [WIDTH-1:0]      cmp_exp_1,
  output logic [WIDTH-1:0]      cmp_exp_2,
  output logic [WIDTH-1:0]      cmp_exp_3,
  input  logic [WIDTH-1:0]      cmp_exp_max,
  input  logic [WIDTH-1:0]      cmp_shift_0,
  input  logic [WIDTH-1:0]      cmp_shift_1,
  input  logic [WIDTH-1:0]      cmp_shift_2,
  input  logic [WIDTH-1:0]      cmp_shift_3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_exp_max,
  output logic [16*WIDTH-1:0]   out_shift,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRP, FINAL, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] exp_reg   [16];
  logic [WIDTH-1:0] gmax      [4];
  logic [WIDTH-1:0] lshift    [16];
  logic [WIDTH-1:0] shift_q   [16];
  logic [WIDTH-1:0] exp_max_q;
  logic [WIDTH-1:0] cmp_ops   [4];
  logic [WIDTH-1:0] cmp_shift [4];

  assign cmp_shift[0] = cmp_shift_0;
  assign cmp_shift[1] = cmp_shift_1;
  assign cmp_shift[2] = cmp_shift_2;
  assign cmp_shift[3] = cmp_shift_3;

  assign cmp_exp_0 = cmp_ops[0];
  assign cmp_exp_1 = cmp_ops[1];
  assign cmp_exp_2 = cmp_ops[2];
  assign cmp_exp_3 = cmp_ops[3];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = GRP;
      end
      GRP: begin
        busy = 1'b1;
        if (cnt_q == 2'd3) state_d = FINAL;
      end
      FINAL: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand k is element 4*cnt+k in group passes, group max k in the final pass.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cmp_ops[k] = '0;
      if (state_q == GRP)   cmp_ops[k] = exp_reg[{cnt_q, 2'(k)}];
      if (state_q == FINAL) cmp_ops[k] = gmax[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      exp_max_q <= '0;
      for (int i = 0; i < 16; i++) begin
        exp_reg[i] <= '0;
        lshift[i]  <= '0;
        shift_q[i] <= '0;
      end
      for (int g = 0; g < 4; g++) gmax[g] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q <= '0;
            for (int i = 0; i < 16; i++) exp_reg[i] <= in_exp[i*WIDTH +: WIDTH];
          end
        end
        GRP: begin
          gmax[cnt_q] <= cmp_exp_max;
          for (int k = 0; k < 4; k++) lshift[{cnt_q, 2'(k)}] <= cmp_shift[k];
          cnt_q <= cnt_q + 2'd1;
        end
        FINAL: begin
          exp_max_q <= cmp_exp_max;
          // Local shift plus the group's distance to the global max; the true sum fits WIDTH bits.
          for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
              shift_q[4*g+k] <= lshift[4*g+k] + cmp_shift[g];
        end
        default: ;
      endcase
    end
  end

  assign out_exp_max = exp_max_q;

  for (genvar i = 0; i < 16; i++) begin : g_out
    assign out_shift[i*WIDTH +: WIDTH] = shift_q[i];
  end

endmodule

// File: tb/tb_exp_align_sched_16in.sv
// Directed bench for exp_align_sched_16in with a behavioural compare unit and a result scoreboard.
module tb_exp_align_sched_16in;
  localparam int W  = 11;
  localparam int VW = 16 * W;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [VW-1:0] in_exp, out_shift;
  logic [W-1:0]  cmp_exp_0, cmp_exp_1, cmp_exp_2, cmp_exp_3, cmp_exp_max;
  logic [W-1:0]  cmp_shift_0, cmp_shift_1, cmp_shift_2, cmp_shift_3, out_exp_max;

  typedef struct packed {
    logic [W-1:0]  mx;
    logic [VW-1:0] sh;
  } res_t;

  res_t sb[$];
  int   pop_cyc[$];
  int   n_vec = 0, n_err = 0, cyc = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  exp_align_sched_16in #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .cmp_exp_0(cmp_exp_0), .cmp_exp_1(cmp_exp_1), .cmp_exp_2(cmp_exp_2), .cmp_exp_3(cmp_exp_3),
    .cmp_exp_max(cmp_exp_max),
    .cmp_shift_0(cmp_shift_0), .cmp_shift_1(cmp_shift_1), .cmp_shift_2(cmp_shift_2), .cmp_shift_3(cmp_shift_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp_max(out_exp_max), .out_shift(out_shift),
    .busy(busy)
  );

  // Combinational 4-input compare unit.
  always_comb begin
    logic [W-1:0] m;
    m = cmp_exp_0;
    if (cmp_exp_1 > m) m = cmp_exp_1;
    if (cmp_exp_2 > m) m = cmp_exp_2;
    if (cmp_exp_3 > m) m = cmp_exp_3;
    cmp_exp_max = m;
    cmp_shift_0 = m - cmp_exp_0;
    cmp_shift_1 = m - cmp_exp_1;
    cmp_shift_2 = m - cmp_exp_2;
    cmp_shift_3 = m - cmp_exp_3;
  end

  function automatic res_t model(input logic [VW-1:0] v);
    res_t r;
    r.mx = '0;
    r.sh = '0;
    for (int i = 0; i < 16; i++) if (v[i*W +: W] > r.mx) r.mx = v[i*W +: W];
    for (int i = 0; i < 16; i++) r.sh[i*W +: W] = r.mx - v[i*W +: W];
    return r;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard bookkeeping on the values that the coming edge will see, then advance one cycle.
  task automatic tick();
    res_t r;
    if (rst) sb.delete();
    else begin
      if (in_valid && in_ready) sb.push_back(model(in_exp));
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL sb_pop: observed unexpected result, expected none pending");
        end else begin
          r = sb.pop_front();
          check("out_exp_max", VW'(out_exp_max), VW'(r.mx));
          check("out_shift", out_shift, r.sh);
        end
      end
    end
    if (busy) busy_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [VW-1:0] v);
    in_exp   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("send_ready", VW'(in_ready), VW'(1'b1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("valid_timeout", VW'(out_valid), VW'(1'b1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [VW-1:0] v);
    int n;
    send(v);
    wait_valid(n);
    drain();
  endtask

  initial begin
    logic [VW-1:0] v_all, v_asc, v_desc, v_one, v_a, v_b;
    res_t          r;
    int            n, acc;
    logic          hs;

    for (int i = 0; i < 16; i++) begin
      v_all[i*W +: W]  = W'(11'h3FF);
      v_asc[i*W +: W]  = W'(i);
      v_desc[i*W +: W] = W'(15 - i);
      v_one[i*W +: W]  = (i == 9) ? W'(11'h7FF) : W'(0);
      v_a[i*W +: W]    = W'($urandom_range(0, 2047));
      v_b[i*W +: W]    = W'($urandom_range(0, 1023));
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_exp = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_flags", VW'({in_ready, out_valid, busy}), VW'(3'b100));
    check("rst_exp_max", VW'(out_exp_max), '0);
    check("rst_shift", out_shift, '0);
    check("rst_cmp_ops", VW'({cmp_exp_0, cmp_exp_1, cmp_exp_2, cmp_exp_3}), '0);

    // All equal: latency from handshake cycle to out_valid is 6 cycles.
    send(v_all);
    wait_valid(n);
    check("latency", VW'(n + 1), VW'(6));
    check("done_cmp_ops", VW'({cmp_exp_0, cmp_exp_1, cmp_exp_2, cmp_exp_3}), '0);
    drain();

    run(v_asc);
    run(v_one);

    // Backpressure: result held, in_ready low, pending vector not taken.
    send(v_a);
    wait_valid(n);
    r        = model(v_a);
    in_exp   = v_b;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_flags", VW'({in_ready, out_valid}), VW'(2'b01));
      check("bp_exp_max", VW'(out_exp_max), VW'(r.mx));
      check("bp_shift", out_shift, r.sh);
      tick();
    end
    check("bp_pending", VW'(sb.size()), VW'(1));
    drain();
    check("bp_idle_ready", VW'(in_ready), VW'(1'b1));
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", VW'(busy), VW'(1'b1));
    wait_valid(n);
    drain();

    // Reset while cnt=2 discards the vector.
    send(v_asc);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_flags", VW'({in_ready, out_valid, busy}), VW'(3'b100));
    check("midrst_shift", out_shift, '0);
    run(v_desc);

    // Back-to-back with out_ready held high.
    pop_cyc.delete();
    busy_cnt  = 0;
    acc       = 0;
    in_exp    = v_a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hs = in_valid && in_ready;
      tick();
      if (hs) begin
        acc++;
        if (acc == 1) in_exp = v_b;
        else          in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("b2b_results", VW'(pop_cyc.size()), VW'(2));
    if (pop_cyc.size() == 2) check("b2b_spacing", VW'(pop_cyc[1] - pop_cyc[0]), VW'(7));
    check("b2b_busy", VW'(busy_cnt), VW'(10));
    check("sb_empty", VW'(sb.size()), VW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/exp_align_sched_16in.md
# exp_align_sched_16in

Sequencer that time-shares one 4-input exponent compare unit (`exp_compare_unit_4in`, combinational) across a 16-exponent vector for the 16-input PE. It finds the vector's maximum exponent and each element's right-shift amount relative to that maximum. It runs four group passes and one final pass over the group maxima, then combines the shifts. It sits between the PE input staging registers and the mantissa alignment shifters, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 11, exponent and shift width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_exp` holds a vector.
- `in_ready` output 1: block accepts a vector this cycle.
- `in_exp` input 16*WIDTH: exponent i is `in_exp[i*WIDTH +: WIDTH]`.
- `cmp_exp_0..3` output WIDTH each: operands driven to the compare unit.
- `cmp_exp_max` input WIDTH: compare unit maximum.
- `cmp_shift_0..3` input WIDTH each: compare unit per-operand shifts (max − operand).
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream takes the result.
- `out_exp_max` output WIDTH: maximum of the 16 exponents.
- `out_shift` output 16*WIDTH: shift i is `out_shift[i*WIDTH +: WIDTH]`, equal to out_exp_max − exponent i.
- `busy` output 1: high in GRP and FINAL.

## Operation
- Group g contains elements 4g..4g+3. The compare-unit operand k carries element 4g+k.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_exp` into `exp_reg`, clear `cnt` to 0, and go to GRP.
- **GRP:**
  - Drive `cmp_exp_k` = `exp_reg[4*cnt+k]`.
  - Each edge captures `gmax[cnt]` ← `cmp_exp_max` and `lshift[4*cnt+k]` ← `cmp_shift_k`.
  - `cnt` increments on each edge. After the edge with `cnt`=3, go to FINAL.
- **FINAL:**
  - Drive `cmp_exp_k` = `gmax[k]`.
  - The edge captures `out_exp_max` ← `cmp_exp_max`.
  - It also captures `out_shift[4g+k]` ← `lshift[4g+k]` + `cmp_shift_g`, using a WIDTH-bit add.
  - The sum equals the true difference and never exceeds 2^WIDTH−1, so no carry out is possible. Implementations keep WIDTH bits only.
  - Go to DONE.
- **DONE:**
  - `out_valid`=1. `out_exp_max` and `out_shift` are held stable.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is 0 in GRP, FINAL and DONE. No new vector is accepted until the result is consumed.
- Outside GRP and FINAL, `cmp_exp_0..3` drive 0.
- Ties (equal exponents) are resolved by the compare unit. Shift values are tie-independent: equal elements all get the same shift, and the maximum elements get 0.
- Exponents are unsigned. A value of 0 is treated as an ordinary exponent; no denormal special-casing happens here.

## Timing
- **Reset values:**
  - State IDLE, `cnt`=0.
  - `in_ready`=1 (the first cycle after reset), `out_valid`=0, `busy`=0.
  - `out_exp_max`=0, `out_shift`=0, `cmp_exp_*`=0.
  - `gmax` and `lshift` are cleared to 0.
- **Latency:**
  - Input handshake on edge E.
  - Groups 0..3 captured on edges E+1..E+4.
  - Final pass on edge E+5. `out_valid` is high in the cycle after E+5.
- **Throughput:** at best one vector per 7 cycles. That is 1 accept, 4 GRP, 1 FINAL, then a DONE cycle with `out_ready`=1, then a return to IDLE.
- **Backpressure:** `out_ready` low holds DONE indefinitely. Outputs do not change, and `in_valid` is ignored.
- **Reset mid-operation:** `rst` high on any edge, in any state, forces the reset values on that edge. A partially processed vector is discarded and no `out_valid` pulse is produced.
- `rst` has priority over all handshakes in the same cycle.
- The compare unit is purely combinational. Its outputs are sampled in the same cycle the operands are driven, with no extra stage.

## Test plan
- **All 16 exponents = 0x3FF:** `out_exp_max`=0x3FF and all shifts = 0. `out_valid` rises 6 cycles after the handshake cycle.
- **Ascending, exponent i = i:** `out_exp_max`=15 and shift i = 15−i. This checks that group offsets are added correctly (e.g. shift 0 = 3 + 12 = 15).
- **Single maximum, element 9 = 0x7FF, others 0, WIDTH=11:** `out_exp_max`=0x7FF, shift 9 = 0, all other shifts = 0x7FF. Covers the maximum-width sum without wrap.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE. Outputs stay stable and `in_ready`=0 throughout. A vector presented during this time is not accepted until after `out_ready` is high and the block has returned to IDLE.
- **Reset during GRP (`cnt`=2):**
  - Next cycle: `in_ready`=1, `out_valid`=0, `out_shift`=0.
  - A fresh descending vector (exponent i = 15−i) then yields `out_exp_max`=15 and shift i = i.
- **Back-to-back:** `in_valid` and `out_ready` held high with two distinct vectors. Exactly two results appear, 7 cycles apart and in order. `busy` is high for exactly 5 cycles per vector.
